// File: rtl/c1_buf_pkg.sv
// Shared types and helpers for the C1 source buffer: fill FSM states, read latency and
// packed-bus slice arithmetic.
package c1_buf_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StFull
  } buf_state_e;

  function automatic int unsigned rd_lat(input int unsigned out_reg);
    return 1 + out_reg;
  endfunction

  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/sdp_ram_sync.sv
// Simple dual-port RAM: one write port, one synchronous read-first read port whose output
// register holds its value while no read is issued.
module sdp_ram_sync #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 6144,
  parameter int unsigned AW    = 13
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/c1_src_buf_np.sv
// N-port source buffer for C1: a frame is broadcast-written into NPORT banks, then read
// through NPORT independent ports with valid pipelining and read-before-write hazard flags.
module c1_src_buf_np
  import c1_buf_pkg::*;
#(
  parameter int unsigned DW      = 16,
  parameter int unsigned DEPTH   = 6144,
  parameter int unsigned AW      = 13,
  parameter int unsigned NPORT   = 5,
  parameter int unsigned OUT_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_frame_start,
  input  logic [AW:0]           i_frame_len,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [DW-1:0]         i_wr_data,
  output logic                  o_buf_full,
  output logic [AW:0]           o_wr_count,
  input  logic [NPORT-1:0]      i_rd_en,
  input  logic [NPORT*AW-1:0]   i_rd_addr,
  output logic [NPORT*DW-1:0]   o_rd_data,
  output logic [NPORT-1:0]      o_rd_valid,
  output logic [NPORT-1:0]      o_rd_err
);

  localparam int unsigned RdLat  = rd_lat(OUT_REG);
  localparam logic [AW:0] LenMax = (AW + 1)'(DEPTH);

  buf_state_e  r_state;
  logic [AW:0] r_wr_count;
  logic [AW:0] r_len;
  logic        r_wr_ready;
  logic        r_buf_full;

  logic          w_len_ok;
  logic          w_accept;
  logic [AW:0]   w_cnt_inc;
  logic [AW-1:0] w_wr_ptr;

  assign w_len_ok  = (i_frame_len != '0) && (i_frame_len <= LenMax);
  assign w_accept  = i_wr_valid & r_wr_ready;
  assign w_cnt_inc = r_wr_count + (AW + 1)'(1);
  // The write pointer tracks the count; it stays below len_q, so no wrap within a frame.
  assign w_wr_ptr  = r_wr_count[AW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_wr_count <= '0;
      r_len      <= '0;
      r_wr_ready <= 1'b0;
      r_buf_full <= 1'b0;
    end else if (i_frame_start && w_len_ok) begin
      r_state    <= StFill;
      r_len      <= i_frame_len;
      r_wr_count <= '0;
      r_wr_ready <= 1'b1;
      r_buf_full <= 1'b0;
    end else begin
      case (r_state)
        StFill: begin
          if (w_accept) begin
            r_wr_count <= w_cnt_inc;
            if (w_cnt_inc == r_len) begin
              r_state    <= StFull;
              r_wr_ready <= 1'b0;
              r_buf_full <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_wr_ready = r_wr_ready;
  assign o_buf_full = r_buf_full;
  assign o_wr_count = r_wr_count;

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    logic [AW-1:0] w_raddr;
    logic [DW-1:0] w_ram_q;
    logic [DW-1:0] w_q_masked;
    logic          w_err_now;
    logic          r_v1;
    logic          r_e1;

    assign w_raddr   = i_rd_addr[slice_lo(p, AW) +: AW];
    // Compared against the count before this cycle's write, so same-address RAW is an error.
    assign w_err_now = ({1'b0, w_raddr} >= r_wr_count) || ({1'b0, w_raddr} >= r_len);

    sdp_ram_sync #(
      .DW   (DW),
      .DEPTH(DEPTH),
      .AW   (AW)
    ) u_bank (
      .clk    (clk),
      .i_we   (w_accept),
      .i_waddr(w_wr_ptr),
      .i_wdata(i_wr_data),
      .i_re   (i_rd_en[p]),
      .i_raddr(w_raddr),
      .o_rdata(w_ram_q)
    );

    // r_e1 resets high so the unreset RAM output register is masked to zero.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v1 <= 1'b0;
        r_e1 <= 1'b1;
      end else begin
        r_v1 <= i_rd_en[p];
        if (i_rd_en[p]) begin
          r_e1 <= w_err_now;
        end
      end
    end

    assign w_q_masked = r_e1 ? '0 : w_ram_q;

    if (RdLat == 1) begin : g_lat1
      assign o_rd_valid[p]                   = r_v1;
      assign o_rd_err[p]                     = r_v1 & r_e1;
      assign o_rd_data[slice_lo(p, DW) +: DW] = w_q_masked;
    end else begin : g_lat2
      logic          r_v2;
      logic          r_e2;
      logic [DW-1:0] r_d2;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_v2 <= 1'b0;
          r_e2 <= 1'b0;
          r_d2 <= '0;
        end else begin
          r_v2 <= r_v1;
          if (r_v1) begin
            r_e2 <= r_e1;
            r_d2 <= w_q_masked;
          end
        end
      end

      assign o_rd_valid[p]                   = r_v2;
      assign o_rd_err[p]                     = r_v2 & r_e2;
      assign o_rd_data[slice_lo(p, DW) +: DW] = r_d2;
    end
  end

endmodule

// File: doc/c1_src_buf_np.md
Name: c1_src_buf_np

Overview:
- Parametrised N-port source buffer for the C1 convolution stage: one frame of pixels streams in once and is broadcast-written into NPORT identical RAM banks.
- NPORT independent read ports then fetch window taps in parallel.
- Adds frame-fill sequencing, write back-pressure, read-valid pipelining and read-before-write hazard flagging on top of a plain banked RAM.
- Sits between the pixel input stream and the C1 window/MAC array.

Parameters:
- DW, 16, pixel data width in bits
- DEPTH, 6144, words per bank; maximum frame length
- AW, 13, address width; must satisfy 2^AW >= DEPTH
- NPORT, 5, number of parallel read ports/banks
- OUT_REG, 1, 1 = extra output register (read latency 2); 0 = read latency 1

Ports:
- clk  in  1  single clock for all logic and RAMs
- rst  in  1  asynchronous active-high reset
- frame_start  in  1  pulse; arms a new fill of frame_len words
- frame_len  in  AW+1  words in frame, sampled on frame_start; legal range 1..DEPTH
- wr_valid  in  1  input pixel valid
- wr_ready  out  1  buffer accepts a pixel this cycle
- wr_data  in  DW  input pixel
- buf_full  out  1  whole frame written; reads fully legal
- wr_count  out  AW+1  number of words written this frame
- rd_en  in  NPORT  per-port read request
- rd_addr  in  NPORT*AW  packed read addresses; port p uses bits [AW*(p+1)-1 : AW*p]
- rd_data  out  NPORT*DW  packed read data, same packing
- rd_valid  out  NPORT  per-port data valid
- rd_err  out  NPORT  per-port hazard flag; qualified by rd_valid

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; wr_ptr=0; wr_count=0; len_q=0.
  - wr_ready=0, buf_full=0, rd_valid=0, rd_err=0, rd_data=0.
  - RAM contents are not cleared.
- FSM states IDLE, FILL, FULL:
  - IDLE: wr_ready=0. frame_start -> FILL; len_q<=frame_len, wr_ptr<=0.
  - FILL: wr_ready=1. On wr_valid&wr_ready, all NPORT banks write wr_data at wr_ptr, and wr_ptr/wr_count increment. The accept that makes wr_count==len_q -> FULL.
  - FULL: wr_ready=0; buf_full=1, asserted the cycle after the last accept.
  - frame_start in FILL or FULL restarts the fill: state FILL, wr_ptr=0, wr_count=0, buf_full=0 next cycle. A wr_valid in that same cycle is accepted only if the state was already FILL; it writes at the old wr_ptr and the word is discarded logically.
  - frame_start with frame_len==0 or >DEPTH: ignored; state unchanged.
- Read, per port p, independent:
  - rd_en[p] is sampled at cycle T.
  - rd_valid[p] is asserted at T+1 when OUT_REG=0, or T+2 when OUT_REG=1, for exactly one cycle per request.
  - Back-to-back requests are pipelined at full rate.
- Hazard check (evaluated at T):
  - rd_err[p]=1 if rd_addr_p >= wr_count (at T, before that cycle's write) or rd_addr_p >= len_q.
  - On error, rd_data slice is forced to 0 with rd_valid still asserted.
  - Same-cycle write/read at equal address: flagged as err; no write-through.
- Read in IDLE: always err (wr_count=0).
- rd_data is held from the last valid read when rd_valid=0, and is 0 after reset.
- Address arithmetic is unsigned; wr_ptr never exceeds len_q-1, with no wrap within a frame.
- Reset mid-fill: immediate IDLE and all outputs to reset values; any in-flight rd_valid is dropped.

Decomposition:
- Package c1_buf_pkg:
  - FSM state enum (IDLE/FILL/FULL)
  - constant RD_LAT = 1+OUT_REG as a function
  - helper for packed slice index
- Sub-module sdp_ram_sync (params DW, DEPTH, AW):
  - simple dual-port, one write port and one synchronous read port, read-first
  - instantiated NPORT times in a generate loop
- Top keeps FSM, counters, and per-port valid/err pipelines.

Test Plan:
- Reset then frame_start, frame_len=8; write 0x0000..0x0007 -> wr_ready=1 for 8 accepts; buf_full=1 on cycle after 8th; wr_count=8.
- FULL; all 5 ports read addr 0,2,4,6,7 same cycle (OUT_REG=1) -> rd_valid=5'b11111 two cycles later, data 0,2,4,6,7, rd_err=0.
- FILL with wr_count=3; port0 reads addr 2, port1 reads addr 3 -> port0 data 0x0002 err=0; port1 data 0 err=1.
- Read addr 8 with len=8 in FULL -> rd_err=1, data 0; continuous rd_en for 4 cycles on port3 -> 4 consecutive rd_valid pulses.
- frame_start mid-fill (wr_count=5), new len=4 -> buf_full stays 0, wr_count resets to 0, full after 4 accepts; frame_len=0 in IDLE -> stays IDLE.
- Assert rst during FILL with reads in flight -> all outputs 0 immediately, no rd_valid afterwards; OUT_REG=0 rerun gives latency 1.
